rr_decoder_arbiter: RTL



---
 rtl/rr_decoder_arbiter_if.sv | 25 ++
 rtl/rr_decoder_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle shared between four requesters
// and the round-robin decoder arbiter.
interface rr_decoder_arbiter_if;
  logic [3:0] req;
  logic [1:0] sel;
  logic       en;
  logic [3:0] gnt;
  logic       busy;

  modport master (
    output req,
    input  sel,
    input  en,
    input  gnt,
    input  busy
  );

  modport slave (
    input  req,
    output sel,
    output en,
    output gnt,
    output busy
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin owner of a 2-to-4 decoder group (A/E/D)
// with a bounded tenure per grant.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_decoder_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;

  logic [1:0] ptr;
  logic [1:0] win;
  logic [7:0] dbl;
  logic [3:0] rot;
  logic       any;
  logic       rel;

  assign ptr = (state_q == GRANT) ? sel_q : last_q;
  assign any = |bus.req;
  assign dbl = {bus.req, bus.req};

  // rot[j] is the candidate j+1 places after ptr; ptr itself is rot[3]
  always_comb begin
    rot = dbl[4'(3'(ptr) + 3'd1) +: 4];
    win = ptr;
    for (int j = 3; j >= 0; j--) begin
      if (rot[j]) win = ptr + 2'(j + 1);
    end
  end

  assign rel = !bus.req[sel_q] ||
               (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          sel_d   = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        unique case (1'b1)
          rel && any: begin
            last_d = sel_q;
            sel_d  = win;
            cnt_d  = '0;
          end
          rel && !any: begin
            last_d  = sel_q;
            state_d = IDLE;
            cnt_d   = '0;
          end
          !rel: begin
            cnt_d = cnt_q + 1'b1;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_d = (state_d == GRANT) ? (4'b0001 << sel_d)
                                    : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.en   = (state_q == GRANT);
  assign bus.busy = (state_q == GRANT);
  assign bus.gnt  = gnt_q;

endmodule
